// File: rtl/timer_pkg.sv
// Shared definitions for the timer: CTRL register bit positions and datapath widths.
package timer_pkg;

    localparam int unsigned CTRL_W = 9;
    localparam int unsigned CNTR_W = 32;

    localparam int unsigned CTRL_EN      = 0;
    localparam int unsigned CTRL_ECLK    = 1;
    localparam int unsigned CTRL_NEC     = 2;
    localparam int unsigned CTRL_OE      = 3;
    localparam int unsigned CTRL_SINGLE  = 4;
    localparam int unsigned CTRL_INTE    = 5;
    localparam int unsigned CTRL_INT     = 6;
    localparam int unsigned CTRL_CNTRRST = 7;
    localparam int unsigned CTRL_CAPTE   = 8;

endpackage

// File: rtl/timer_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin, plus an edge-detect flop giving rise/fall pulses.
module timer_sync_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise_c,
    output logic o_fall_c
);

    logic meta_q;
    logic sync_q;
    logic last_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            last_q <= 1'b0;
        end else begin
            meta_q <= i_pin;
            sync_q <= meta_q;
            last_q <= sync_q;
        end
    end

    assign o_level  = sync_q;
    assign o_rise_c = sync_q & ~last_q;
    assign o_fall_c = ~sync_q & last_q;

endmodule

// File: rtl/timer_count_core.sv
// Timer counting engine: counter, PWM, LRC-match interrupt, single-shot stop and pin capture.
module timer_count_core
    import timer_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [CNTR_W-1:0] i_hrc,
    input  logic [CNTR_W-1:0] i_lrc,
    input  logic              i_cntr_we,
    input  logic [CNTR_W-1:0] i_cntr_wdata,
    input  logic              i_ecgt,
    input  logic              i_capt,
    input  logic              i_int_clr,
    output logic [CNTR_W-1:0] o_cntr,
    output logic              o_pwm,
    output logic              o_int_pulse,
    output logic              o_irq,
    output logic              o_stopped,
    output logic              o_capt_hrc_we,
    output logic              o_capt_lrc_we,
    output logic [CNTR_W-1:0] o_capt_data
);

    logic ecgt_lvl, ecgt_rise, ecgt_fall;
    logic capt_lvl, capt_rise, capt_fall;

    timer_sync_edge u_sync_ecgt (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_pin    (i_ecgt),
        .o_level  (ecgt_lvl),
        .o_rise_c (ecgt_rise),
        .o_fall_c (ecgt_fall)
    );

    timer_sync_edge u_sync_capt (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_pin    (i_capt),
        .o_level  (capt_lvl),
        .o_rise_c (capt_rise),
        .o_fall_c (capt_fall)
    );

    // OE and INT are owned by the register file; capture only needs the edges.
    logic unused_ok;
    assign unused_ok = ^{i_ctrl[CTRL_OE], i_ctrl[CTRL_INT], capt_lvl};

    logic en, eclk, nec, single, inte, cntrrst, capte;
    assign en      = i_ctrl[CTRL_EN];
    assign eclk    = i_ctrl[CTRL_ECLK];
    assign nec     = i_ctrl[CTRL_NEC];
    assign single  = i_ctrl[CTRL_SINGLE];
    assign inte    = i_ctrl[CTRL_INTE];
    assign cntrrst = i_ctrl[CTRL_CNTRRST];
    assign capte   = i_ctrl[CTRL_CAPTE];

    logic [CNTR_W-1:0] cntr_q, cntr_d, capt_data_q, capt_data_d, cntr_inc;
    logic pwm_q, pwm_d, pulse_d, irq_q, irq_d, stopped_q, stopped_d;
    logic hrc_we_d, lrc_we_d;
    logic fire, inc, adv, lrc_hit, hrc_hit;

    // Next-state logic; software write and CNTRRST suppress the increment entirely.
    always_comb begin
        fire        = eclk ? (nec ? ecgt_fall : ecgt_rise) : (ecgt_lvl ^ nec);
        inc         = en & ~stopped_q & ~capte & fire;
        adv         = inc & ~cntrrst & ~i_cntr_we;
        cntr_inc    = cntr_q + CNTR_W'(1);
        lrc_hit     = adv & (i_lrc != '0) & (cntr_q == i_lrc);
        hrc_hit     = adv & (i_hrc != '0) & (cntr_inc == i_hrc)
                      & ((i_lrc == '0) | (i_hrc <= i_lrc));

        cntr_d = cntr_q;
        if (cntrrst) begin
            cntr_d = '0;
        end else if (i_cntr_we) begin
            cntr_d = i_cntr_wdata;
        end else if (lrc_hit) begin
            cntr_d = '0;
        end else if (adv) begin
            cntr_d = cntr_inc;
        end

        pwm_d = pwm_q;
        if (lrc_hit) begin
            pwm_d = 1'b0;
        end else if (hrc_hit) begin
            pwm_d = 1'b1;
        end

        pulse_d = lrc_hit & inte;
        irq_d   = pulse_d | (irq_q & ~i_int_clr);

        stopped_d = stopped_q;
        if (i_cntr_we || cntrrst || !en) begin
            stopped_d = 1'b0;
        end else if (lrc_hit && single) begin
            stopped_d = 1'b1;
        end

        hrc_we_d    = capte & capt_rise;
        lrc_we_d    = capte & capt_fall;
        capt_data_d = (hrc_we_d || lrc_we_d) ? cntr_d : capt_data_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cntr_q        <= '0;
            pwm_q         <= 1'b0;
            o_int_pulse   <= 1'b0;
            irq_q         <= 1'b0;
            stopped_q     <= 1'b0;
            o_capt_hrc_we <= 1'b0;
            o_capt_lrc_we <= 1'b0;
            capt_data_q   <= '0;
        end else begin
            cntr_q        <= cntr_d;
            pwm_q         <= pwm_d;
            o_int_pulse   <= pulse_d;
            irq_q         <= irq_d;
            stopped_q     <= stopped_d;
            o_capt_hrc_we <= hrc_we_d;
            o_capt_lrc_we <= lrc_we_d;
            capt_data_q   <= capt_data_d;
        end
    end

    assign o_cntr      = cntr_q;
    assign o_pwm       = pwm_q;
    assign o_irq       = irq_q;
    assign o_stopped   = stopped_q;
    assign o_capt_data = capt_data_q;

endmodule

// File: tb/tb_timer_count_core.sv
// Bench for timer_count_core: directed scenarios plus random traffic against a cycle-level reference model.
module tb_timer_count_core;
    import timer_pkg::*;

    localparam logic [8:0] B_EN      = 9'h001;
    localparam logic [8:0] B_ECLK    = 9'h002;
    localparam logic [8:0] B_NEC     = 9'h004;
    localparam logic [8:0] B_SINGLE  = 9'h010;
    localparam logic [8:0] B_INTE    = 9'h020;
    localparam logic [8:0] B_CNTRRST = 9'h080;
    localparam logic [8:0] B_CAPTE   = 9'h100;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [8:0]  i_ctrl;
    logic [31:0] i_hrc, i_lrc, i_cntr_wdata;
    logic        i_cntr_we, i_ecgt, i_capt, i_int_clr;
    logic [31:0] o_cntr, o_capt_data;
    logic        o_pwm, o_int_pulse, o_irq, o_stopped, o_capt_hrc_we, o_capt_lrc_we;

    timer_count_core dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_ctrl        (i_ctrl),
        .i_hrc         (i_hrc),
        .i_lrc         (i_lrc),
        .i_cntr_we     (i_cntr_we),
        .i_cntr_wdata  (i_cntr_wdata),
        .i_ecgt        (i_ecgt),
        .i_capt        (i_capt),
        .i_int_clr     (i_int_clr),
        .o_cntr        (o_cntr),
        .o_pwm         (o_pwm),
        .o_int_pulse   (o_int_pulse),
        .o_irq         (o_irq),
        .o_stopped     (o_stopped),
        .o_capt_hrc_we (o_capt_hrc_we),
        .o_capt_lrc_we (o_capt_lrc_we),
        .o_capt_data   (o_capt_data)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    endtask

    // Reference model state; pin histories hold the value seen at each of the last three edges.
    logic [31:0] m_cntr, m_cdata;
    logic        m_pwm, m_pulse, m_irq, m_stop, m_hwe, m_lwe;
    logic        ep1, ep2, ep3, cp1, cp2, cp3;

    task automatic model_edge();
        logic en, eclk, nec, single, inte, cntrrst, capte;
        logic lvl_e, prev_e, lvl_c, prev_c, fire, counting, hit, hset;
        logic [32:0] nxt;
        if (i_rst) begin
            m_cntr = 0; m_cdata = 0; m_pwm = 0; m_pulse = 0; m_irq = 0; m_stop = 0;
            m_hwe = 0; m_lwe = 0;
            {ep1, ep2, ep3, cp1, cp2, cp3} = '0;
            return;
        end
        en = i_ctrl[CTRL_EN]; eclk = i_ctrl[CTRL_ECLK]; nec = i_ctrl[CTRL_NEC];
        single = i_ctrl[CTRL_SINGLE]; inte = i_ctrl[CTRL_INTE];
        cntrrst = i_ctrl[CTRL_CNTRRST]; capte = i_ctrl[CTRL_CAPTE];
        // A pin value seen at edge k acts at edge k+2.
        lvl_e = ep2; prev_e = ep3; lvl_c = cp2; prev_c = cp3;
        ep3 = ep2; ep2 = ep1; ep1 = i_ecgt;
        cp3 = cp2; cp2 = cp1; cp1 = i_capt;

        if (eclk) fire = nec ? (prev_e && !lvl_e) : (!prev_e && lvl_e);
        else      fire = (lvl_e != nec);
        counting = en && !m_stop && !capte && fire && !cntrrst && !i_cntr_we;
        hit  = counting && (i_lrc != 0) && (m_cntr == i_lrc);
        nxt  = ({1'b0, m_cntr} + 33'd1) % 33'h1_0000_0000;
        hset = counting && !hit && (i_hrc != 0) && (nxt[31:0] == i_hrc)
               && !((i_lrc != 0) && (i_hrc > i_lrc));

        if (hit) m_pwm = 0;
        else if (hset) m_pwm = 1;

        if (cntrrst)        m_cntr = 0;
        else if (i_cntr_we) m_cntr = i_cntr_wdata;
        else if (hit)       m_cntr = 0;
        else if (counting)  m_cntr = nxt[31:0];

        m_pulse = hit && inte;
        if (m_pulse) m_irq = 1;
        else if (i_int_clr) m_irq = 0;

        if (i_cntr_we || cntrrst || !en) m_stop = 0;
        else if (hit && single) m_stop = 1;

        m_hwe = capte && lvl_c && !prev_c;
        m_lwe = capte && !lvl_c && prev_c;
        if (m_hwe || m_lwe) m_cdata = m_cntr;
    endtask

    task automatic tick();
        @(posedge i_clk);
        model_edge();
        #1;
        check("cntr",      o_cntr,        m_cntr);
        check("pwm",       32'(o_pwm),    32'(m_pwm));
        check("int_pulse", 32'(o_int_pulse), 32'(m_pulse));
        check("irq",       32'(o_irq),    32'(m_irq));
        check("stopped",   32'(o_stopped), 32'(m_stop));
        check("capt_hrc",  32'(o_capt_hrc_we), 32'(m_hwe));
        check("capt_lrc",  32'(o_capt_lrc_we), 32'(m_lwe));
        check("capt_data", o_capt_data,   m_cdata);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic write_cntr(input logic [31:0] v);
        i_cntr_we = 1; i_cntr_wdata = v;
        tick();
        i_cntr_we = 0;
    endtask

    initial begin
        int guard;
        i_rst = 1; i_ctrl = 0; i_hrc = 0; i_lrc = 0; i_cntr_we = 0; i_cntr_wdata = 0;
        i_ecgt = 0; i_capt = 0; i_int_clr = 0;
        ticks(2);
        check("rst_cntr", o_cntr, 32'd0);
        check("rst_irq",  32'(o_irq), 32'd0);

        // Basic PWM with an open gate.
        i_rst = 0; i_ctrl = B_EN | B_INTE; i_hrc = 2; i_lrc = 5; i_ecgt = 1;
        ticks(30);
        check("pwm_irq_held", 32'(o_irq), 32'd1);
        i_int_clr = 1; tick(); i_int_clr = 0;
        ticks(8);

        // External clock counted on falling edges; ten pulses with period 4 leave 2.
        i_ctrl = B_EN | B_ECLK | B_NEC; i_lrc = 3; i_hrc = 0;
        write_cntr(0);
        for (int p = 0; p < 10; p++) begin
            i_ecgt = 0; ticks(2);
            i_ecgt = 1; ticks(2);
        end
        ticks(4);
        check("eclk_final", o_cntr, 32'd2);

        // Single shot stops after one period and resumes on a write.
        i_ctrl = B_EN | B_SINGLE | B_INTE; i_lrc = 4;
        write_cntr(0);
        ticks(10);
        check("single_stopped", 32'(o_stopped), 32'd1);
        check("single_cntr", o_cntr, 32'd0);
        write_cntr(0);
        ticks(3);
        check("single_resumed", o_cntr, 32'd3);

        // Write beats a simultaneous match; CNTRRST beats a write; set beats clear.
        i_ctrl = B_EN | B_INTE; i_lrc = 5;
        i_int_clr = 1; write_cntr(4); i_int_clr = 0;
        tick();
        write_cntr(32'h10);
        check("prio_write", o_cntr, 32'h10);
        check("prio_noirq", 32'(o_irq), 32'd0);
        i_ctrl = B_EN | B_INTE | B_CNTRRST;
        write_cntr(32'h77);
        check("prio_cntrrst", o_cntr, 32'd0);
        i_ctrl = B_EN | B_INTE;
        write_cntr(4);
        tick();
        i_int_clr = 1; tick(); i_int_clr = 0;
        check("prio_set_wins", 32'(o_irq), 32'd1);
        check("prio_pulse", 32'(o_int_pulse), 32'd1);

        // Silent 32-bit wrap with LRC disabled.
        i_lrc = 0; i_int_clr = 1; write_cntr(32'hFFFF_FFFE); i_int_clr = 0;
        tick();
        check("wrap_max", o_cntr, 32'hFFFF_FFFF);
        tick();
        check("wrap_zero", o_cntr, 32'd0);
        check("wrap_noirq", 32'(o_irq), 32'd0);

        // Capture freezes a software-loaded value on both pin edges.
        i_ctrl = B_EN | B_CAPTE | B_INTE;
        write_cntr(32'h55);
        i_capt = 1; ticks(3);
        check("capt_hrc_we", 32'(o_capt_hrc_we), 32'd1);
        check("capt_hrc_data", o_capt_data, 32'h55);
        i_capt = 0; ticks(3);
        check("capt_lrc_we", 32'(o_capt_lrc_we), 32'd1);
        check("capt_lrc_data", o_capt_data, 32'h55);
        ticks(2);

        // Reset mid-period with cntr=3, pwm=1, irq=1.
        i_ctrl = B_EN | B_INTE; i_hrc = 2; i_lrc = 5;
        write_cntr(0);
        guard = 0;
        while (!(o_cntr == 3 && o_pwm && o_irq) && guard < 40) begin
            tick(); guard++;
        end
        check("midrst_pre_cntr", o_cntr, 32'd3);
        check("midrst_pre_irq", 32'(o_irq), 32'd1);
        i_rst = 1; tick();
        check("midrst_cntr", o_cntr, 32'd0);
        check("midrst_pwm", 32'(o_pwm), 32'd0);
        check("midrst_irq", 32'(o_irq), 32'd0);
        i_rst = 0;

        // Random traffic checked every cycle by the model.
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 39) == 0) begin
                i_ctrl = 9'($urandom) & ~B_CNTRRST;
                if ($urandom_range(0, 5) == 0) i_ctrl = i_ctrl | B_CNTRRST;
                if ($urandom_range(0, 2) == 0) i_ctrl = i_ctrl & ~B_CAPTE;
                i_ctrl = i_ctrl | B_EN;
                if ($urandom_range(0, 7) == 0) i_ctrl = i_ctrl & ~B_EN;
                i_hrc = 32'($urandom_range(0, 7));
                i_lrc = 32'($urandom_range(0, 7));
            end
            i_cntr_we = ($urandom_range(0, 15) == 0);
            i_cntr_wdata = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFD + 32'($urandom_range(0, 2))
                                                       : 32'($urandom_range(0, 9));
            if ($urandom_range(0, 2) == 0) i_ecgt = ~i_ecgt;
            if ($urandom_range(0, 4) == 0) i_capt = ~i_capt;
            i_int_clr = ($urandom_range(0, 9) == 0);
            i_rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        i_rst = 0; i_cntr_we = 0; i_int_clr = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
